// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//
// Single-bus 32-bit processor datapath driven entirely by an external control
// unit. One 32-bit bus connects the register file, special registers, ALU,
// memory data register and I/O ports. Every register loads from the bus (or
// its dedicated source) on the rising clock edge while its load enable is high.
//
// Ports
//   Clock         system clock, all state changes on the rising edge
//   clear         asynchronous active-low reset of every register (not memory)
//   Read          MDR input select: 1 = memory word at MAR, 0 = bus
//   Write         store MDR into mem[MAR[8:0]] on the rising edge
//   IncPC         forces the ALU result to {32'h0, bus + 1}
//   opcode        ALU operation select
//   Gra/Grb/Grc   gate IR fields Ra/Rb/Rc into the register selector
//   Rin/Rout      write / drive the selected general register
//   BAout         drive the selected register, with R0 reading as zero
//   *in           register load enables
//   *out, Cout    bus drive enables (fixed priority, bus = 0 when none active)
//   InPort_input  external input-port data
//
// There are no output ports; state is observed through the internal registers.
// -----------------------------------------------------------------------------
module datapath (
  input logic        Clock,
  input logic        clear,
  input logic        Read,
  input logic        Write,
  input logic        IncPC,
  input logic [4:0]  opcode,
  input logic        Gra,
  input logic        Grb,
  input logic        Grc,
  input logic        Rin,
  input logic        Rout,
  input logic        BAout,
  input logic        HIin,
  input logic        LOin,
  input logic        Yin,
  input logic        Zin,
  input logic        PCin,
  input logic        IRin,
  input logic        MARin,
  input logic        MDRin,
  input logic        Inportin,
  input logic        Outportin,
  input logic        CONin,
  input logic        HIout,
  input logic        LOout,
  input logic        Yout,
  input logic        Zhighout,
  input logic        Zlowout,
  input logic        PCout,
  input logic        MARout,
  input logic        MDRout,
  input logic        Inportout,
  input logic        Outportout,
  input logic        Cout,
  input logic [31:0] InPort_input
);

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010,
    OP_BR   = 5'b10011
  } alu_op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q;
  logic [31:0] inport_q, outport_q;
  logic [63:0] z_q;
  logic        con_q;

  // NOTE: memory contents are deliberately outside the reset domain; a reset
  // must not destroy program/data memory, and RAM macros have no reset anyway.
  // The declaration initializer gives the all-zero power-up contents.
  logic [31:0] mem [512] = '{default: 32'h0};

  logic [31:0] bus;
  logic [31:0] mem_rd;
  logic [31:0] mdr_d;
  logic [63:0] z_d;
  logic        con_d;

  // ---------------------------------------------------------------------------
  // IR field decode
  // ---------------------------------------------------------------------------
  logic [3:0]  ra, rb, rc;
  logic [1:0]  c2;
  logic [31:0] c_ext;
  logic [3:0]  reg_sel;
  logic [15:0] reg_sel_oh;
  logic        ir_op_unused;

  assign ra    = ir_q[26:23];
  assign rb    = ir_q[22:19];
  assign rc    = ir_q[18:15];
  assign c2    = ir_q[20:19];
  assign c_ext = {{13{ir_q[18]}}, ir_q[18:0]};

  // The op field is consumed by the external control unit, not by the datapath.
  assign ir_op_unused = ^ir_q[31:27];

  assign reg_sel    = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);
  assign reg_sel_oh = 16'd1 << reg_sel;

  assign mem_rd = mem[mar_q[8:0]];

  // ---------------------------------------------------------------------------
  // Bus multiplexer, fixed priority
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    bus = '0;
    if (Rout) begin
      bus = r_q[reg_sel];
    end else if (BAout) begin
      // Base-address read: R0 acts as a hard zero so "R0 + offset" is absolute.
      bus = (reg_sel == 4'd0) ? '0 : r_q[reg_sel];
    end else if (HIout) begin
      bus = hi_q;
    end else if (LOout) begin
      bus = lo_q;
    end else if (Zhighout) begin
      bus = z_q[63:32];
    end else if (Zlowout) begin
      bus = z_q[31:0];
    end else if (PCout) begin
      bus = pc_q;
    end else if (MDRout) begin
      bus = mdr_q;
    end else if (Inportout) begin
      bus = inport_q;
    end else if (Cout) begin
      bus = c_ext;
    end else if (Yout) begin
      bus = y_q;
    end else if (MARout) begin
      bus = mar_q;
    end else if (Outportout) begin
      bus = outport_q;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU: A = Y, B = bus
  // ---------------------------------------------------------------------------
  alu_op_e            op;
  logic [4:0]         sh;
  logic signed [31:0] a_s, b_s;
  logic [63:0]        prod;
  logic [31:0]        alu_lo, alu_hi;

  assign op   = alu_op_e'(opcode);
  assign sh   = bus[4:0];
  assign a_s  = y_q;
  assign b_s  = bus;
  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // product the exact signed result.
  assign prod = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};

  always_comb begin
    alu_lo = bus;
    alu_hi = '0;
    if (IncPC) begin
      alu_lo = bus + 32'd1;
    end else begin
      case (op)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR: alu_lo = y_q + bus;
        OP_SUB:          alu_lo = y_q - bus;
        OP_AND, OP_ANDI: alu_lo = y_q & bus;
        OP_OR,  OP_ORI:  alu_lo = y_q | bus;
        // A shift count of 0 turns the complementary shift into a shift by 32,
        // which yields 0, so rotates by 0 return A unchanged.
        OP_ROR:  alu_lo = (y_q >> sh) | (y_q << (6'd32 - {1'b0, sh}));
        OP_ROL:  alu_lo = (y_q << sh) | (y_q >> (6'd32 - {1'b0, sh}));
        OP_SHR:  alu_lo = y_q >> sh;
        OP_SHRA: alu_lo = a_s >>> sh;
        OP_SHL:  alu_lo = y_q << sh;
        OP_DIV: begin
          if (bus != '0) begin
            alu_lo = a_s / b_s;
            alu_hi = a_s % b_s;
          end else begin
            alu_lo = '0;
          end
        end
        OP_MUL: begin
          alu_lo = prod[31:0];
          alu_hi = prod[63:32];
        end
        OP_NEG:  alu_lo = -bus;
        OP_NOT:  alu_lo = ~bus;
        default: alu_lo = bus;
      endcase
    end
  end

  assign z_d = {alu_hi, alu_lo};

  // ---------------------------------------------------------------------------
  // Register next-state sources
  // ---------------------------------------------------------------------------
  assign mdr_d = Read ? mem_rd : bus;

  always_comb begin
    con_d = 1'b0;
    case (c2)
      2'b00: con_d = (bus == '0);
      2'b01: con_d = (bus != '0);
      2'b10: con_d = ~bus[31];
      2'b11: con_d = bus[31];
      default: con_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. The asynchronous clear wins over every load on the same edge.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge bus value, independent of statement order.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      z_q       <= '0;
      con_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (Rin && reg_sel_oh[i]) r_q[i] <= bus;
      end
      if (HIin)      hi_q      <= bus;
      if (LOin)      lo_q      <= bus;
      if (Yin)       y_q       <= bus;
      if (Zin)       z_q       <= z_d;
      if (PCin)      pc_q      <= bus;
      if (IRin)      ir_q      <= bus;
      if (MARin)     mar_q     <= bus;
      if (MDRin)     mdr_q     <= mdr_d;
      if (Inportin)  inport_q  <= InPort_input;
      if (Outportin) outport_q <= bus;
      if (CONin)     con_q     <= con_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Write) mem[mar_q[8:0]] <= mdr_q;
  end

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath
//
// Directed-vector bench for datapath. Drives control signals one cycle at a
// time, observes internal registers hierarchically and compares them against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_datapath;

  logic        Clock;
  logic        clear;
  logic        Read, Write, IncPC;
  logic [4:0]  opcode;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin;
  logic        Inportin, Outportin, CONin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout;
  logic        Inportout, Outportout, Cout;
  logic [31:0] InPort_input;

  int checks;
  int errors;

  datapath dut (
    .Clock        (Clock),
    .clear        (clear),
    .Read         (Read),
    .Write        (Write),
    .IncPC        (IncPC),
    .opcode       (opcode),
    .Gra          (Gra),
    .Grb          (Grb),
    .Grc          (Grc),
    .Rin          (Rin),
    .Rout         (Rout),
    .BAout        (BAout),
    .HIin         (HIin),
    .LOin         (LOin),
    .Yin          (Yin),
    .Zin          (Zin),
    .PCin         (PCin),
    .IRin         (IRin),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .Inportin     (Inportin),
    .Outportin    (Outportin),
    .CONin        (CONin),
    .HIout        (HIout),
    .LOout        (LOout),
    .Yout         (Yout),
    .Zhighout     (Zhighout),
    .Zlowout      (Zlowout),
    .PCout        (PCout),
    .MARout       (MARout),
    .MDRout       (MDRout),
    .Inportout    (Inportout),
    .Outportout   (Outportout),
    .Cout         (Cout),
    .InPort_input (InPort_input)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_ctrl();
    Read = 0; Write = 0; IncPC = 0; opcode = 5'b0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
    HIin = 0; LOin = 0; Yin = 0; Zin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0;
    Inportin = 0; Outportin = 0; CONin = 0;
    HIout = 0; LOout = 0; Yout = 0; Zhighout = 0; Zlowout = 0; PCout = 0;
    MARout = 0; MDRout = 0; Inportout = 0; Outportout = 0; Cout = 0;
  endtask

  // One control step: the settings made before the call are sampled on the
  // next rising edge, then everything returns to idle 1 time unit later.
  task automatic tick();
    @(posedge Clock);
    #1;
    clr_ctrl();
  endtask

  task automatic inport_set(input logic [31:0] v);
    InPort_input = v; Inportin = 1; tick();
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    inport_set(addr);
    Inportout = 1; MARin = 1; tick();
    inport_set(data);
    Inportout = 1; MDRin = 1; tick();
    Write = 1; tick();
  endtask

  task automatic fetch();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; tick();
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    inport_set(a);
    Inportout = 1; Yin = 1; tick();
    inport_set(b);
    Inportout = 1; opcode = op; Zin = 1; tick();
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } alu_vec_t;

  alu_vec_t vecs [20] = '{
    '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 64'h0},
    '{5'b00100, 32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE},
    '{5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000},
    '{5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_FFF0FFF0},
    '{5'b00111, 32'h80000001, 32'h00000004, 64'h00000000_18000000},
    '{5'b01000, 32'h80000001, 32'h00000004, 64'h00000000_00000018},
    '{5'b01001, 32'h80000001, 32'h00000004, 64'h00000000_08000000},
    '{5'b01010, 32'h80000001, 32'h00000004, 64'h00000000_F8000000},
    '{5'b01011, 32'h80000001, 32'h00000004, 64'h00000000_00000010},
    '{5'b00111, 32'h80000001, 32'h00000020, 64'h00000000_80000001},
    '{5'b01000, 32'h80000001, 32'h0000001F, 64'h00000000_C0000000},
    '{5'b10001, 32'h00000000, 32'h00000001, 64'h00000000_FFFFFFFF},
    '{5'b10010, 32'h00000000, 32'h0000FFFF, 64'h00000000_FFFF0000},
    '{5'b11111, 32'h00000000, 32'h12345678, 64'h00000000_12345678},
    '{5'b10000, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA},
    '{5'b01111, 32'h00000007, 32'h00000002, 64'h00000001_00000003},
    '{5'b01111, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD},
    '{5'b01111, 32'h00000007, 32'h00000000, 64'h0},
    '{5'b01101, 32'hFFFF0000, 32'h0F0F0F0F, 64'h00000000_0F0F0000},
    '{5'b10011, 32'h7FFFFFFF, 32'h00000001, 64'h00000000_80000000}
  };

  initial begin
    checks = 0;
    errors = 0;
    InPort_input = '0;
    clr_ctrl();
    clear = 1'b0;
    #12;
    clear = 1'b1;
    #1;

    // Reset state
    check("rst_pc",  dut.pc_q,   0);
    check("rst_z",   dut.z_q,    0);
    check("rst_con", dut.con_q,  0);
    check("rst_r5",  dut.r_q[5], 0);

    // Program: ldi R5,0x25 at 0 and jr R5 at 1, then clear between edges
    mem_write(32'd0, 32'h0A800025);
    mem_write(32'd1, 32'hA2800000);
    clear = 1'b0; #2; clear = 1'b1; #1;
    check("clr_mar",       dut.mar_q,  0);
    check("clr_mem0_kept", dut.mem[0], 32'h0A800025);

    // Fetch
    fetch();
    check("fetch_mar", dut.mar_q, 0);
    check("fetch_pc",  dut.pc_q,  1);
    check("fetch_ir",  dut.ir_q,  32'h0A800025);

    // ldi R5, 0x25
    Grb = 1; BAout = 1; Yin = 1; tick();
    check("ldi_y", dut.y_q, 0);
    Cout = 1; opcode = 5'b00011; Zin = 1; tick();
    check("ldi_z", dut.z_q, 64'h25);
    Zlowout = 1; Gra = 1; Rin = 1; tick();
    check("ldi_r5", dut.r_q[5], 32'h25);

    // jr R5
    fetch();
    check("jr_ir", dut.ir_q, 32'hA2800000);
    Gra = 1; Rout = 1; PCin = 1; tick();
    check("jr_pc", dut.pc_q, 32'h25);

    // R0: BAout reads zero, Rout reads the stored value (IR Rb = 0)
    inport_set(32'h55);
    Inportout = 1; Grb = 1; Rin = 1; tick();
    Grb = 1; BAout = 1; Yin = 1; tick();
    check("r0_baout", dut.y_q, 0);
    Grb = 1; Rout = 1; Yin = 1; tick();
    check("r0_rout", dut.y_q, 32'h55);

    // Store then load back through Read
    mem_write(32'h10, 32'hDEADBEEF);
    check("st_mem16", dut.mem[16], 32'hDEADBEEF);
    inport_set(32'h0);
    Inportout = 1; MDRin = 1; tick();
    check("ld_mdr_cleared", dut.mdr_q, 0);
    Read = 1; MDRin = 1; tick();
    check("ld_mdr", dut.mdr_q, 32'hDEADBEEF);

    // ALU table
    for (int i = 0; i < 20; i++) begin
      alu_run(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("alu%0d_op%b", i, vecs[i].op), dut.z_q, vecs[i].z);
    end

    // IncPC overrides the opcode; bus + 1 wraps
    inport_set(32'hFFFFFFFF);
    Inportout = 1; IncPC = 1; opcode = 5'b10000; Zin = 1; tick();
    check("incpc_override", dut.z_q, 0);

    // Bus priority: Zlowout beats PCout
    inport_set(32'h1234);
    Inportout = 1; PCin = 1; tick();
    check("pc_load", dut.pc_q, 32'h1234);
    Zlowout = 1; PCout = 1; MARin = 1; tick();
    check("prio_zlow_over_pc", dut.mar_q, 0);

    // CON: C2=00 on R5 (nonzero) -> 0
    inport_set(32'h02800000);
    Inportout = 1; IRin = 1; tick();
    Gra = 1; Rout = 1; CONin = 1; tick();
    check("con_eq0_r5", dut.con_q, 0);
    // C2=00 on R3 (zero) -> 1
    inport_set(32'h01800000);
    Inportout = 1; IRin = 1; tick();
    Gra = 1; Rout = 1; CONin = 1; tick();
    check("con_eq0_r3", dut.con_q, 1);
    // C2=11 on R5 (positive) -> 0
    inport_set(32'h02980000);
    Inportout = 1; IRin = 1; tick();
    Gra = 1; Rout = 1; CONin = 1; tick();
    check("con_neg_r5", dut.con_q, 0);
    // C2=01 on R5 (nonzero) -> 1
    inport_set(32'h02880000);
    Inportout = 1; IRin = 1; tick();
    Gra = 1; Rout = 1; CONin = 1; tick();
    check("con_ne0_r5", dut.con_q, 1);

    // Reset between edges clears everything at once; held across an edge it
    // blocks a concurrent load.
    clear = 1'b0;
    #1;
    check("rst_async_con", dut.con_q,   0);
    check("rst_async_r0",  dut.r_q[0],  0);
    check("rst_async_r5",  dut.r_q[5],  0);
    check("rst_async_pc",  dut.pc_q,    0);
    check("rst_async_ir",  dut.ir_q,    0);
    check("rst_async_mdr", dut.mdr_q,   0);
    check("rst_async_y",   dut.y_q,     0);
    InPort_input = 32'h77; Inportin = 1;
    tick();
    check("rst_prio_inport", dut.inport_q, 0);
    clear = 1'b1;
    #1;
    check("rst_mem16_kept", dut.mem[16], 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  in  1  single system clock; all state changes on rising edge.
REQ-002 clear  in  1  reset: asynchronous, active-low.
REQ-003 Read, Write, IncPC  in  1 each  memory read select; memory write enable; PC-increment ALU override.
REQ-004 opcode  in  5  ALU operation select.
REQ-005 Gra, Grb, Grc, Rin, Rout, BAout  in  1 each  select-and-encode controls.
REQ-006 HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin  in  1 each  register load enables, in this port order.
REQ-007 HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout, Inportout, Outportout, Cout  in  1 each  bus drive enables, in this port order.
REQ-008 InPort_input  in  32  external input-port data.
REQ-009 The port order SHALL be exactly as listed in REQ-001..REQ-008, with no output ports.

Function
REQ-010 There SHALL be one 32-bit bus.
- Bus source priority: Rout/BAout register, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout, Yout, MARout, Outportout.
- No enable asserted: bus = 0.
REQ-011 Internal registers SHALL be named R[0..15], HI, LO, Y, PC, IR, MAR, MDR, InPort, OutPort (32 bits each), Z (64 bits) and CON (1 bit); each loads on a rising edge while its in-signal is high.
REQ-012 IR fields SHALL be decoded as follows.
- op = IR[31:27]; Ra = IR[26:23]; Rb = IR[22:19]; Rc = IR[18:15].
- C2 = IR[20:19].
- C = IR[18:0] sign-extended to 32 bits; Cout drives C.
REQ-013 Register select SHALL be the OR of (Gra&Ra, Grb&Rb, Grc&Rc), one-hot decoded.
- Rin writes the selected register from the bus.
- Rout drives the selected register onto the bus.
- BAout drives the selected register, except that selecting R0 drives 0.
- Rout on R0 drives the true R0 value.
REQ-014 The ALU SHALL be combinational, with A = Y and B = bus; Zin latches the 64-bit result {Zhigh, Zlow}.
REQ-015 The ALU opcode map SHALL be as follows; Zhigh = 0 unless stated.
- 00000, 00001, 00010, 00011, 01100, 10011: A+B (mod 2^32).
- 00100: A-B; 00101, 01101: A&B; 00110, 01110: A|B.
- 00111: ror A by B[4:0]; 01000: rol A by B[4:0].
- 01001: shr A by B[4:0] (logical); 01010: shra A by B[4:0] (arithmetic); 01011: shl A by B[4:0].
- 01111: signed divide; Zlow = A/B, Zhigh = A%B; B = 0 gives Z = 0.
- 10000: signed multiply; Z = 64-bit A*B.
- 10001: -B; 10010: ~B; all other opcodes: Zlow = B.
REQ-016 IncPC=1 SHALL override opcode: Z = {0, bus+1}.
REQ-017 Memory SHALL be an internal array mem of 512x32, addressed by MAR[8:0] and zero-initialized at time 0.
- Read is combinational.
- Write=1 stores MDR to mem[MAR[8:0]] on the rising edge.
REQ-018 The MDR input SHALL be mem[MAR[8:0]] when Read=1, else the bus.
REQ-019 The InPort register SHALL load InPort_input each edge while Inportin=1; OutPort SHALL load from the bus when Outportin=1.
REQ-020 CON SHALL load on CONin with a condition on the bus value (the Ra value) selected by C2.
- 00: bus == 0.
- 01: bus != 0.
- 10: bus[31] == 0.
- 11: bus[31] == 1.
REQ-021 Simultaneous in-signals SHALL all load the same bus value in the same edge.

Reset
REQ-022 clear=0 SHALL asynchronously set every register, including R0..R15, Z and CON, to 0; mem SHALL be unaffected.
REQ-023 A reset asserted mid-sequence SHALL take priority over any load on the same edge.

Verification
REQ-024 Fetch: mem[0] = 0x0A800025 (ldi R5, 0x25).
- Stimulus: PCout+MARin+IncPC+Zin, then Zlowout+PCin+Read+MDRin, then MDRout+IRin.
- Required: MAR = 0, PC = 1, IR = 0x0A800025.
REQ-025 ldi execute, following REQ-024.
- Stimulus: Grb+BAout+Yin, then Cout+opcode 00011+Zin, then Zlowout+Gra+Rin.
- Required: Y = 0, Z = 0x25, R5 = 0x25.
REQ-026 jr: mem[1] = 0xA2800000, run after REQ-025.
- Stimulus: fetch, then Gra+Rout+PCin.
- Required: PC = 0x25.
REQ-027 Store/load: MAR = 0x10, MDR = 0xDEADBEEF, Write=1 for one edge.
- Required: mem[16] = 0xDEADBEEF.
- Then MAR = 0x10 with Read+MDRin: MDR = 0xDEADBEEF.
REQ-028 Multiply/divide.
- Y = 0xFFFFFFFE (-2), bus = 3, opcode 10000: Z = 0xFFFFFFFF_FFFFFFFA.
- Y = 7, bus = 2, opcode 01111: Zlow = 3, Zhigh = 1.
REQ-029 CON and reset.
- R3 = 0, IR C2 = 00, Gra selecting R3 + Rout + CONin: CON = 1.
- Then clear=0 between clock edges: all registers read 0 immediately.
